// File: rtl/cva6_hpdcache_refill_upsizer.sv
// Refill upsizer: packs memory refill beats into data-RAM chunks tagged with offset/first/last/id/error.
// Optional macro HPDCACHE_REFILL_FEEDTHROUGH_EN lets a completing beat bypass an empty chunk FIFO.
module cva6_hpdcache_refill_upsizer #(
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned CL_WORDS       = 8,
    parameter int unsigned ACCESS_WORDS   = 4,
    parameter int unsigned MEM_DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned ID_WIDTH       = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               mem_valid_i,
    output logic                               mem_ready_o,
    input  logic [MEM_DATA_WIDTH-1:0]          mem_data_i,
    input  logic [ID_WIDTH-1:0]                mem_id_i,
    input  logic                               mem_error_i,
    input  logic                               mem_last_i,
    output logic                               chunk_valid_o,
    input  logic                               chunk_ready_i,
    output logic [ACCESS_WORDS*WORD_WIDTH-1:0] chunk_data_o,
    output logic [$clog2(CL_WORDS)-1:0]        chunk_word_o,
    output logic                               chunk_first_o,
    output logic                               chunk_last_o,
    output logic [ID_WIDTH-1:0]                chunk_id_o,
    output logic                               chunk_error_o,
    output logic                               proto_err_o
);

    localparam int unsigned CHUNK_W = ACCESS_WORDS * WORD_WIDTH;
    localparam int unsigned BPC     = CHUNK_W / MEM_DATA_WIDTH;
    localparam int unsigned CPL     = CL_WORDS / ACCESS_WORDS;
    localparam int unsigned BC_W    = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned CC_W    = (CPL > 1) ? $clog2(CPL) : 1;
    localparam int unsigned WOFF_W  = $clog2(CL_WORDS);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [CHUNK_W-1:0]  data;
        logic [WOFF_W-1:0]   word;
        logic                first;
        logic                last;
        logic [ID_WIDTH-1:0] id;
        logic                error;
    } chunk_t;

    logic [MEM_DATA_WIDTH-1:0] acc_q [BPC];
    logic [BC_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CC_W-1:0]           chunk_cnt_q, chunk_cnt_d;
    logic                      err_sticky_q, err_sticky_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic                      proto_err_q, proto_err_d;
    chunk_t                    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]          cnt_q;

    logic   beat_end_s, chunk_end_s, line_final_s, early_last_s, missing_last_s;
    logic   complete_s, full_s, empty_s, accept_s, push_s, fifo_pop_s, bypass_s, out_valid_s;
    chunk_t push_ent_s, out_ent_s;

    // Beat classification, flow control and construction of the chunk to push.
    always_comb begin
        beat_end_s     = (beat_cnt_q == BC_W'(BPC - 1));
        chunk_end_s    = (chunk_cnt_q == CC_W'(CPL - 1));
        line_final_s   = beat_end_s && chunk_end_s;
        early_last_s   = mem_last_i && !line_final_s;
        missing_last_s = !mem_last_i && line_final_s;
        complete_s     = beat_end_s || mem_last_i;
        full_s         = (cnt_q == CNT_W'(FIFO_DEPTH));
        empty_s        = (cnt_q == '0);
        fifo_pop_s     = !empty_s && chunk_ready_i;
        mem_ready_o    = !complete_s || !full_s || fifo_pop_s;
        accept_s       = mem_valid_i && mem_ready_o;

        push_ent_s = '0;
        // Slots beyond the current beat are zero so an early-terminated chunk is padded.
        for (int i = 0; i < BPC; i++) begin
            if (BC_W'(i) < beat_cnt_q) begin
                push_ent_s.data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = acc_q[i];
            end else if (BC_W'(i) == beat_cnt_q) begin
                push_ent_s.data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_data_i;
            end else begin
                push_ent_s.data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = '0;
            end
        end
        push_ent_s.word  = WOFF_W'(chunk_cnt_q) * WOFF_W'(ACCESS_WORDS);
        push_ent_s.first = (chunk_cnt_q == '0);
        push_ent_s.last  = chunk_end_s || mem_last_i;
        push_ent_s.id    = (beat_cnt_q == '0) ? mem_id_i : id_q;
        push_ent_s.error = err_sticky_q || mem_error_i || early_last_s || missing_last_s;

`ifdef HPDCACHE_REFILL_FEEDTHROUGH_EN
        out_valid_s = !empty_s || (mem_valid_i && complete_s);
        out_ent_s   = empty_s ? push_ent_s : fifo_q[rd_ptr_q];
        bypass_s    = empty_s && mem_valid_i && complete_s && chunk_ready_i;
`else
        out_valid_s = !empty_s;
        out_ent_s   = fifo_q[rd_ptr_q];
        bypass_s    = 1'b0;
`endif
        push_s = accept_s && complete_s && !bypass_s;
    end

    // Next-state of the beat/chunk counters, sticky error, latched ID and protocol pulse.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        chunk_cnt_d  = chunk_cnt_q;
        err_sticky_d = err_sticky_q;
        id_d         = id_q;
        proto_err_d  = 1'b0;
        if (accept_s) begin
            proto_err_d = early_last_s || missing_last_s;
            if (beat_cnt_q == '0) begin
                id_d = mem_id_i;
            end else begin
                id_d = id_q;
            end
            if (!complete_s) begin
                beat_cnt_d   = beat_cnt_q + BC_W'(1);
                err_sticky_d = err_sticky_q || mem_error_i;
            end else if (push_ent_s.last) begin
                beat_cnt_d   = '0;
                chunk_cnt_d  = '0;
                err_sticky_d = 1'b0;
            end else begin
                beat_cnt_d   = '0;
                chunk_cnt_d  = chunk_cnt_q + CC_W'(1);
                err_sticky_d = err_sticky_q || mem_error_i;
            end
        end else begin
            proto_err_d = 1'b0;
        end
    end

    // Accumulator, counters and protocol pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BPC; i++) acc_q[i] <= '0;
            beat_cnt_q   <= '0;
            chunk_cnt_q  <= '0;
            err_sticky_q <= 1'b0;
            id_q         <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            if (accept_s) acc_q[beat_cnt_q] <= mem_data_i;
            beat_cnt_q   <= beat_cnt_d;
            chunk_cnt_q  <= chunk_cnt_d;
            err_sticky_q <= err_sticky_d;
            id_q         <= id_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Chunk FIFO: circular buffer; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= push_ent_s;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, fifo_pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign chunk_valid_o = out_valid_s;
    assign chunk_data_o  = out_ent_s.data;
    assign chunk_word_o  = out_ent_s.word;
    assign chunk_first_o = out_ent_s.first;
    assign chunk_last_o  = out_ent_s.last;
    assign chunk_id_o    = out_ent_s.id;
    assign chunk_error_o = out_ent_s.error;
    assign proto_err_o   = proto_err_q;

endmodule

// File: doc/cva6_hpdcache_refill_upsizer.md
Name: cva6_hpdcache_refill_upsizer

Overview:
- Sits between the NoC/memory refill response channel and the HPDcache refill path; consumes the memory-side refill beats that feed the HPDcache data RAM.
- Packs narrow memory beats into ACCESS_WORDS-wide chunks, which is the data-RAM write granularity.
- Tags each chunk with its word offset, first/last flags, transaction ID and sticky error.
- Buffers complete chunks in a small FIFO so the refill handler can stall without back-pressuring the memory interface on every beat.

Parameters:
- WORD_WIDTH, 64, cache word width in bits (XLEN).
- CL_WORDS, 8, words per cacheline.
- ACCESS_WORDS, 4, words per data-RAM access (chunk); must divide CL_WORDS.
- MEM_DATA_WIDTH, 64, memory beat width; must divide ACCESS_WORDS*WORD_WIDTH and be a multiple of WORD_WIDTH.
- FIFO_DEPTH, 2, chunk FIFO entries (>=1).
- ID_WIDTH, 4, refill transaction ID width.
- Derived: BEATS_PER_CHUNK = ACCESS_WORDS*WORD_WIDTH/MEM_DATA_WIDTH; CHUNKS_PER_LINE = CL_WORDS/ACCESS_WORDS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_valid_i  in  1  refill beat valid
- mem_ready_o  out  1  refill beat accepted when valid&ready
- mem_data_i  in  MEM_DATA_WIDTH  beat data, low word first
- mem_id_i  in  ID_WIDTH  transaction ID (constant within a line)
- mem_error_i  in  1  beat carries bus error
- mem_last_i  in  1  final beat of the cacheline
- chunk_valid_o  out  1  chunk available
- chunk_ready_i  in  1  consumer accepts chunk
- chunk_data_o  out  ACCESS_WORDS*WORD_WIDTH  chunk data
- chunk_word_o  out  clog2(CL_WORDS)  word offset of chunk in line
- chunk_first_o  out  1  first chunk of line
- chunk_last_o  out  1  last chunk of line
- chunk_id_o  out  ID_WIDTH  transaction ID
- chunk_error_o  out  1  sticky error for line so far
- proto_err_o  out  1  one-cycle pulse on mem_last mismatch

Behaviour:
- Reset (async, rst_ni=0):
  - beat_cnt=0, chunk_cnt=0, err_sticky=0, FIFO empty, accumulator cleared.
  - Outputs: mem_ready_o=1, chunk_valid_o=0, proto_err_o=0, data/tag outputs 0.
- Reset mid-line: the partial chunk and all FIFO contents are discarded. The next accepted beat is treated as beat 0 of a new line.
- Beat accept:
  - Write the beat to accumulator slot beat_cnt; beat_cnt wraps at BEATS_PER_CHUNK.
  - err_sticky |= mem_error_i.
- Chunk completion (beat_cnt==BEATS_PER_CHUNK-1):
  - Push {data, word=chunk_cnt*ACCESS_WORDS, first=(chunk_cnt==0), last=(chunk_cnt==CHUNKS_PER_LINE-1), id, err_sticky|mem_error_i}.
  - chunk_cnt increments and wraps to 0 after the last chunk.
  - err_sticky is cleared after the last chunk.
- Flow control:
  - Non-completing beats are always accepted.
  - A completing beat is accepted only if the FIFO is not full, or a pop occurs in the same cycle (fall-through ready).
  - Otherwise mem_ready_o=0, and the accumulator and counters hold.
- Output timing:
  - Chunk visible on chunk_valid_o the cycle after the completing beat's accept edge (latency 1).
  - Chunks are emitted in order; outputs are stable while valid&&!ready.
- Simultaneous push and pop on a full FIFO: both occur; occupancy is unchanged.
- Line-end check:
  - If mem_last_i is asserted on an accepted beat that is not the final beat of the line, or deasserted on the final beat, pulse proto_err_o for one cycle.
  - If mem_last_i came early: force the pushed chunk's last=1 and error=1. beat_cnt and chunk_cnt return to 0; a partial chunk is pushed padded with zeros.
  - If mem_last_i is missing: counters wrap normally and the chunk carries error=1.
- mem_id_i is latched on beat 0 of each chunk.

Optional Feature:
- Macro HPDCACHE_REFILL_FEEDTHROUGH_EN.
- Defined: when the FIFO is empty, a completing beat drives chunk_valid_o combinationally in the same cycle. If chunk_ready_i=1 the chunk bypasses the FIFO (no push), giving latency 0. If chunk_ready_i=0 it is pushed normally.
- Undefined: all chunks pass through the FIFO with latency 1, and there are no combinational paths from mem_* to chunk_*.

Test Plan:
- Defaults; 8 back-to-back beats with words 0x0..0x7, id=3, last on beat 7, chunk_ready=1 -> chunks {word=0, first=1, data words 0..3} and {word=4, last=1, data words 4..7}, each 1 cycle after its 4th/8th beat; proto_err_o=0.
- chunk_ready=0 for a stream of 3 lines -> 2 chunks fill the FIFO. The 4th beat of the third chunk sees mem_ready_o=0 and holds until one pop, then is accepted in that pop cycle.
- mem_error_i=1 on beat 2 only -> chunk0 error=1 and chunk1 error=1; the next line's chunks have error=0.
- mem_last_i=1 on beat 5 -> proto_err_o pulses once; chunk1 has last=1, error=1, words 6..7 zero. The next beat starts word 0.
- rst_ni low after beat 2 -> chunk_valid_o=0 immediately. After release, 8 new beats yield exactly 2 correct chunks.
- With HPDCACHE_REFILL_FEEDTHROUGH_EN and chunk_ready=1 -> chunk_valid_o is asserted in the same cycle as beats 3 and 7, and the FIFO stays empty.
